// File: rtl/oled_text_buffer_if.sv
// Byte-stream port for the OLED text buffer: a source pushes characters, the buffer applies them.
interface oled_text_buffer_if;
  logic [7:0] i_CHAR;
  logic       i_CHAR_VALID;
  logic       o_CHAR_READY;

  modport master (output i_CHAR, output i_CHAR_VALID, input o_CHAR_READY);
  modport slave  (input i_CHAR, input i_CHAR_VALID, output o_CHAR_READY);
endinterface

// File: rtl/oled_text_buffer.sv
// Character terminal in front of OLED_interface: edits a live text screen and hands
// tear-free snapshots to the display with a start/ready refresh handshake.
module oled_text_buffer #(
  parameter int NUM_ASCII_COL = 12,
  parameter int NUM_ASCII_ROW = 8,
  parameter int BUSY_TIMEOUT  = 16
) (
  input  logic                                   i_CLK,
  input  logic                                   i_RST,
  oled_text_buffer_if.slave                      char_bus,
  input  logic                                   i_CLEAR,
  input  logic                                   i_READY,
  output logic                                   o_START,
  output logic [NUM_ASCII_COL*NUM_ASCII_ROW*8-1:0] o_ASCII,
  output logic [3:0]                             o_CURSOR_COL,
  output logic [2:0]                             o_CURSOR_ROW,
  output logic                                   o_DIRTY,
  output logic [3:0]                             o_FSM_STATE
);
  localparam int TOTAL = NUM_ASCII_COL * NUM_ASCII_ROW;
  localparam int W     = TOTAL * 8;
  localparam int ROW_W = NUM_ASCII_COL * 8;
  localparam int IDX_W = $clog2(TOTAL);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [3:0]       LAST_COL = 4'(NUM_ASCII_COL - 1);
  localparam logic [2:0]       LAST_ROW = 3'(NUM_ASCII_ROW - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR} edit_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT_BUSY, R_WAIT_DONE} ref_state_t;

  edit_state_t      edit_state, edit_next;
  ref_state_t       ref_state, ref_next;
  logic [W-1:0]     live, live_d, shadow;
  logic [3:0]       col, col_d;
  logic [2:0]       row, row_d;
  logic [IDX_W-1:0] clr_idx, clr_idx_d;
  logic [TMO_W-1:0] tmo, tmo_d;
  logic             dirty, dirty_set, start, timeout;
  logic             wr_en, do_scroll;
  logic [7:0]       wr_char, ch;
  int               wr_idx, cur_idx;

  // Valid/ready: a byte transfers on any rising edge where i_CHAR_VALID and
  // o_CHAR_READY are both high; the source may hold or change i_CHAR otherwise.
  assign ch = char_bus.i_CHAR;

  always_comb begin
    edit_next = edit_state;
    live_d    = live;
    col_d     = col;
    row_d     = row;
    clr_idx_d = clr_idx;
    dirty_set = 1'b0;
    wr_en     = 1'b0;
    wr_char   = 8'h20;
    do_scroll = 1'b0;
    cur_idx   = int'(row) * NUM_ASCII_COL + int'(col);
    wr_idx    = cur_idx;
    case (edit_state)
      S_IDLE: edit_next = S_RUN;
      S_RUN: begin
        if (i_CLEAR) begin
          edit_next = S_CLEAR;
          clr_idx_d = '0;
        end else if (char_bus.i_CHAR_VALID) begin
          if (ch >= 8'h20 && ch <= 8'h7E) begin
            wr_en     = 1'b1;
            wr_char   = ch;
            dirty_set = 1'b1;
            if (col == LAST_COL) begin
              col_d = '0;
              if (row == LAST_ROW) do_scroll = 1'b1;
              else row_d = row + 3'd1;
            end else begin
              col_d = col + 4'd1;
            end
          end else if (ch == 8'h0D) begin
            col_d = '0;
          end else if (ch == 8'h0A) begin
            col_d = '0;
            if (row == LAST_ROW) begin
              do_scroll = 1'b1;
              dirty_set = 1'b1;
            end else begin
              row_d = row + 3'd1;
            end
          end else if (ch == 8'h08 && (col != '0 || row != '0)) begin
            // The cell left of the cursor is always linear index - 1, even across a row.
            wr_en     = 1'b1;
            wr_idx    = cur_idx - 1;
            dirty_set = 1'b1;
            if (col != '0) begin
              col_d = col - 4'd1;
            end else begin
              row_d = row - 3'd1;
              col_d = LAST_COL;
            end
          end
        end
      end
      S_CLEAR: begin
        wr_en  = 1'b1;
        wr_idx = int'(clr_idx);
        if (clr_idx == LAST_IDX) begin
          edit_next = S_RUN;
          col_d     = '0;
          row_d     = '0;
          dirty_set = 1'b1;
        end else begin
          clr_idx_d = clr_idx + 1'b1;
        end
      end
      default: edit_next = S_IDLE;
    endcase
    if (wr_en) live_d[(TOTAL - 1 - wr_idx) * 8 +: 8] = wr_char;
    if (do_scroll) live_d = {live_d[W-ROW_W-1:0], {NUM_ASCII_COL{8'h20}}};
  end

  always_comb begin
    ref_next = ref_state;
    tmo_d    = tmo;
    start    = 1'b0;
    timeout  = 1'b0;
    case (ref_state)
      R_IDLE: begin
        if (dirty && i_READY && edit_state != S_CLEAR) begin
          start    = 1'b1;
          ref_next = R_WAIT_BUSY;
          tmo_d    = '0;
        end
      end
      R_WAIT_BUSY: begin
        if (!i_READY) begin
          ref_next = R_WAIT_DONE;
        end else if (tmo == LAST_TMO) begin
          // Display never acknowledged: give up and re-arm so the snapshot is resent.
          ref_next = R_IDLE;
          timeout  = 1'b1;
        end else begin
          tmo_d = tmo + 1'b1;
        end
      end
      R_WAIT_DONE: if (i_READY) ref_next = R_IDLE;
      default: ref_next = R_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      edit_state <= S_IDLE;
      ref_state  <= R_IDLE;
      live       <= {TOTAL{8'h20}};
      shadow     <= {TOTAL{8'h20}};
      col        <= '0;
      row        <= '0;
      clr_idx    <= '0;
      tmo        <= '0;
      dirty      <= 1'b0;
    end else begin
      edit_state <= edit_next;
      ref_state  <= ref_next;
      live       <= live_d;
      col        <= col_d;
      row        <= row_d;
      clr_idx    <= clr_idx_d;
      tmo        <= tmo_d;
      // A coincident edit wins over the snapshot's clear so the change is not lost.
      dirty      <= (dirty_set || timeout) ? 1'b1 : (start ? 1'b0 : dirty);
      if (start) shadow <= live;
    end
  end

  assign char_bus.o_CHAR_READY = (edit_state == S_RUN);
  assign o_START      = start;
  assign o_ASCII      = shadow;
  assign o_CURSOR_COL = col;
  assign o_CURSOR_ROW = row;
  assign o_DIRTY      = dirty;
  assign o_FSM_STATE  = {edit_state, ref_state};
endmodule

// File: tb/tb_oled_text_buffer.sv
// Bench for oled_text_buffer: directed scenarios plus random byte traffic against a
// screen-level reference model with a simple display responder.
module tb_oled_text_buffer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         ready = 1'b1;
  logic         o_start, o_dirty;
  logic [767:0] o_ascii;
  logic [3:0]   o_col;
  logic [2:0]   o_row;
  logic [3:0]   o_fsm;

  int n_cmp = 0;
  int n_err = 0;

  oled_text_buffer_if cbus ();

  oled_text_buffer dut (
    .i_CLK(clk), .i_RST(rst_n), .char_bus(cbus), .i_CLEAR(clear), .i_READY(ready),
    .o_START(o_start), .o_ASCII(o_ascii), .o_CURSOR_COL(o_col), .o_CURSOR_ROW(o_row),
    .o_DIRTY(o_dirty), .o_FSM_STATE(o_fsm)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_scr [8][12];
  logic [7:0] m_sh  [8][12];
  int m_r, m_c, m_clr_left, m_tmo, n_start;
  bit m_dirty, m_ready, m_inflight, m_saw_busy, m_edit_dirty;

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [767:0] pack_live();
    logic [767:0] v;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++) v[(95 - (r * 12 + c)) * 8 +: 8] = m_scr[r][c];
    return v;
  endfunction

  function automatic logic [767:0] pack_shadow();
    logic [767:0] v;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++) v[(95 - (r * 12 + c)) * 8 +: 8] = m_sh[r][c];
    return v;
  endfunction

  task automatic m_blank();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++) m_scr[r][c] = 8'h20;
  endtask

  task automatic m_scroll();
    for (int r = 0; r < 7; r++) m_scr[r] = m_scr[r + 1];
    for (int c = 0; c < 12; c++) m_scr[7][c] = 8'h20;
  endtask

  task automatic m_newline();
    m_c = 0;
    m_r++;
    if (m_r == 8) begin
      m_scroll();
      m_r = 7;
      m_edit_dirty = 1'b1;
    end
  endtask

  task automatic m_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      m_scr[m_r][m_c] = b;
      m_edit_dirty = 1'b1;
      m_c++;
      if (m_c == 12) m_newline();
    end else if (b == 8'h0D) begin
      m_c = 0;
    end else if (b == 8'h0A) begin
      m_newline();
    end else if (b == 8'h08) begin
      if (m_c > 0) begin
        m_c--;
        m_scr[m_r][m_c] = 8'h20;
        m_edit_dirty = 1'b1;
      end else if (m_r > 0) begin
        m_r--;
        m_c = 11;
        m_scr[m_r][m_c] = 8'h20;
        m_edit_dirty = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit exp_start, new_dirty;
    if (!rst_n) begin
      m_blank();
      m_sh = m_scr;
      m_r = 0; m_c = 0; m_clr_left = 0; m_tmo = 0;
      m_dirty = 0; m_ready = 0; m_inflight = 0; m_saw_busy = 0;
    end else begin
      chk("ready", 768'(cbus.o_CHAR_READY), 768'(m_ready));
      chk("dirty", 768'(o_dirty), 768'(m_dirty));
      chk("cur_col", 768'(o_col), 768'(m_c));
      chk("cur_row", 768'(o_row), 768'(m_r));
      chk("shadow", o_ascii, pack_shadow());
      exp_start = !m_inflight && m_dirty && ready && (m_clr_left == 0);
      chk("start", 768'(o_start), 768'(exp_start));
      new_dirty = m_dirty;
      if (exp_start) begin
        m_sh = m_scr;
        new_dirty = 0;
        m_inflight = 1;
        m_saw_busy = 0;
        m_tmo = 0;
        n_start++;
      end else if (m_inflight) begin
        if (!m_saw_busy) begin
          if (!ready) m_saw_busy = 1;
          else begin
            m_tmo++;
            if (m_tmo == 16) begin
              m_inflight = 0;
              new_dirty = 1;
            end
          end
        end else if (ready) begin
          m_inflight = 0;
        end
      end
      m_edit_dirty = 0;
      if (m_clr_left > 0) begin
        m_clr_left--;
        if (m_clr_left == 0) begin
          m_blank();
          m_r = 0; m_c = 0;
          m_edit_dirty = 1;
          m_ready = 1;
        end
      end else if (!m_ready) begin
        m_ready = 1;
      end else if (clear) begin
        m_clr_left = 96;
        m_ready = 0;
      end else if (cbus.i_CHAR_VALID) begin
        m_apply(cbus.i_CHAR);
      end
      m_dirty = m_edit_dirty ? 1'b1 : new_dirty;
    end
  end

  // ---------------- display responder ----------------
  int disp_mode = 0;   // 0: auto busy pulse after each start, 1: ready follows ready_req
  logic ready_req = 1'b1;
  int busy_left = 0;

  always @(posedge clk) begin
    logic s;
    s = o_start;
    #1;
    if (disp_mode == 0) begin
      if (!rst_n) begin
        busy_left = 0;
        ready = 1'b1;
      end else if (s) begin
        busy_left = $urandom_range(2, 8);
        ready = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) ready = 1'b1;
      end else begin
        ready = 1'b1;
      end
    end else begin
      ready = ready_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cbus.o_CHAR_READY && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("ready_timeout", 768'(cbus.o_CHAR_READY), 768'(1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready();
    cbus.i_CHAR = b;
    cbus.i_CHAR_VALID = 1'b1;
    @(posedge clk);
    #1 cbus.i_CHAR_VALID = 1'b0;
  endtask

  task automatic do_clear(input logic with_byte, input logic [7:0] b);
    wait_ready();
    clear = 1'b1;
    cbus.i_CHAR = b;
    cbus.i_CHAR_VALID = with_byte;
    @(posedge clk);
    #1;
    clear = 1'b0;
    cbus.i_CHAR_VALID = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    @(negedge clk);
    while ((m_dirty || m_inflight || m_clr_left != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("quiet_timeout", 768'(m_dirty), 768'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    disp_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [767:0] blank;
    logic [95:0]  exp_row7;
    int s0, cnt;
    blank = {96{8'h20}};
    exp_row7 = {8'h59, {11{8'h20}}};
    cbus.i_CHAR = 8'h00;
    cbus.i_CHAR_VALID = 1'b0;
    n_start = 0;

    repeat (3) @(negedge clk);
    chk("rst_ascii", o_ascii, blank);
    chk("rst_ready", 768'(cbus.o_CHAR_READY), 768'(0));
    chk("rst_start", 768'(o_start), 768'(0));
    chk("rst_dirty", 768'(o_dirty), 768'(0));
    chk("rst_cursor", 768'({o_row, o_col}), 768'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 768'(cbus.o_CHAR_READY), 768'(1));

    // "HI"
    s0 = n_start;
    send_byte(8'h48);
    send_byte(8'h49);
    wait_quiet();
    chk("hi_bytes", 768'(o_ascii[767 -: 16]), 768'(16'h4849));
    chk("hi_rest", 768'(o_ascii[751:0]), 768'(blank[751:0]));
    chk("hi_cursor", 768'({o_row, o_col}), 768'({3'd0, 4'd2}));
    chk("hi_live", o_ascii, pack_live());
    chk("hi_starts_ge1", 768'(n_start - s0 >= 1), 768'(1));

    // 12 'A' then 'B'
    do_reset();
    repeat (12) send_byte(8'h41);
    send_byte(8'h42);
    wait_quiet();
    chk("wrap_row0", 768'(o_ascii[767 -: 96]), 768'({12{8'h41}}));
    chk("wrap_cell10", 768'(o_ascii[671 -: 8]), 768'(8'h42));
    chk("wrap_cursor", 768'({o_row, o_col}), 768'({3'd1, 4'd1}));

    // 96 'X' then 'Y' scrolls
    do_reset();
    repeat (96) send_byte(8'h58);
    send_byte(8'h59);
    wait_quiet();
    chk("scroll_top", 768'(o_ascii[767:96]), 768'({84{8'h58}}));
    chk("scroll_row7", 768'(o_ascii[95:0]), 768'(exp_row7));
    chk("scroll_cursor", 768'({o_row, o_col}), 768'({3'd7, 4'd1}));

    // backspace across a row, then at home
    do_reset();
    repeat (12) send_byte(8'h61);
    wait_quiet();
    send_byte(8'h08);
    wait_quiet();
    chk("bs_cursor", 768'({o_row, o_col}), 768'({3'd0, 4'd11}));
    chk("bs_cell", 768'(o_ascii[(95 - 11) * 8 +: 8]), 768'(8'h20));
    repeat (11) send_byte(8'h08);
    wait_quiet();
    send_byte(8'h08);
    @(negedge clk);
    chk("bs_home_dirty", 768'(o_dirty), 768'(0));
    chk("bs_home_cursor", 768'({o_row, o_col}), 768'(0));

    // clear with a coincident byte
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(33, 126)));
    wait_quiet();
    s0 = n_start;
    do_clear(1'b1, 8'h5A);
    cnt = 0;
    @(negedge clk);
    while (!cbus.o_CHAR_READY && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("clear_ready_low", 768'(cnt), 768'(96));
    wait_quiet();
    chk("clear_screen", o_ascii, blank);
    chk("clear_cursor", 768'({o_row, o_col}), 768'(0));
    chk("clear_one_start", 768'(n_start - s0), 768'(1));

    // write while the display is busy
    s0 = n_start;
    disp_mode = 1;
    ready_req = 1'b1;
    send_byte(8'h51);
    cnt = 0;
    while (!m_inflight && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    ready_req = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h52);
    repeat (10) @(negedge clk);
    chk("busy_hold", o_ascii, pack_shadow());
    chk("busy_q", 768'(o_ascii[767 -: 8]), 768'(8'h51));
    chk("busy_r_pending", 768'(o_ascii[759 -: 8]), 768'(8'h20));
    chk("busy_dirty", 768'(o_dirty), 768'(1));
    disp_mode = 0;
    wait_quiet();
    chk("busy_two_starts", 768'(n_start - s0), 768'(2));
    chk("busy_final", o_ascii, pack_live());

    // display never acknowledges
    disp_mode = 1;
    ready_req = 1'b1;
    send_byte(8'h54);
    s0 = n_start;
    repeat (40) @(posedge clk);
    #1;
    chk("timeout_reissue", 768'(n_start - s0), 768'(3));
    disp_mode = 0;
    wait_quiet();
    chk("timeout_final", o_ascii, pack_live());

    // random traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int pick;
      pick = $urandom_range(0, 19);
      if ($urandom_range(0, 59) == 0) do_clear(1'($urandom_range(0, 1)), 8'($urandom_range(32, 126)));
      else if (pick == 0) send_byte(8'h0D);
      else if (pick <= 2) send_byte(8'h0A);
      else if (pick <= 4) send_byte(8'h08);
      else if (pick == 5) send_byte(8'($urandom_range(0, 31)));
      else if (pick == 6) send_byte(8'($urandom_range(127, 255)));
      else send_byte(8'($urandom_range(32, 126)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_quiet();
    chk("rand_final", o_ascii, pack_live());
    chk("rand_cursor", 768'({o_row, o_col}), 768'({3'(m_r), 4'(m_c)}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
